// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with selectable polarity and an autonomous
// scan mode that steps the active line through channels 0..i_last at a set rate.
module decoder_scan #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [SEL_W-1:0]      i_last,
  input  logic [DIV_W-1:0]      i_div,
  input  logic                  i_opt,
  output logic [2**SEL_W-1:0]   o_y,
  output logic [SEL_W-1:0]      o_idx,
  output logic                  o_tick
);

  localparam int N = 2**SEL_W;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]     hot, hot_d;
  logic [SEL_W-1:0] idx, idx_d, idx_nxt;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic             tick, tick_d;
  logic             mode_q, en_q;

  // idx never exceeds N-1, so idx+1 cannot wrap past the last channel by accident.
  assign idx_nxt = (idx >= i_last) ? '0 : idx + 1'b1;

  always_comb begin
    hot_d  = hot;
    idx_d  = idx;
    cnt_d  = '0;
    tick_d = 1'b0;
    if (!i_en) begin
      hot_d = '0;
    end else if (!i_mode) begin
      idx_d = i_sel;
      hot_d = ONE << i_sel;
    end else if (!mode_q || !en_q) begin
      // First scan edge: light the held index and restart the prescaler.
      hot_d = ONE << idx;
    end else if (cnt == i_div) begin
      tick_d = 1'b1;
      idx_d  = idx_nxt;
      hot_d  = ONE << idx_nxt;
    end else begin
      cnt_d = cnt + 1'b1;
      hot_d = ONE << idx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hot    <= '0;
      idx    <= '0;
      cnt    <= '0;
      tick   <= 1'b0;
      mode_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      hot    <= hot_d;
      idx    <= idx_d;
      cnt    <= cnt_d;
      tick   <= tick_d;
      mode_q <= i_mode;
      en_q   <= i_en;
    end
  end

  // Polarity is the only combinational input-to-output path.
  assign o_y    = i_opt ? hot : ~hot;
  assign o_idx  = idx;
  assign o_tick = tick;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed-vector bench for decoder_scan (SEL_W=3, DIV_W=16).
module tb_decoder_scan;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_mode;
  logic [2:0]  i_sel;
  logic [2:0]  i_last;
  logic [15:0] i_div;
  logic        i_opt;
  logic [7:0]  o_y;
  logic [2:0]  o_idx;
  logic        o_tick;

  int vectors = 0;
  int miscompares = 0;

  decoder_scan #(.SEL_W(3), .DIV_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode),
    .i_sel(i_sel), .i_last(i_last), .i_div(i_div), .i_opt(i_opt),
    .o_y(o_y), .o_idx(o_idx), .o_tick(o_tick)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] y, input logic [2:0] idx, input logic tk);
    chk({tag, ".y"}, {24'd0, o_y}, {24'd0, y});
    chk({tag, ".idx"}, {29'd0, o_idx}, {29'd0, idx});
    chk({tag, ".tick"}, {31'd0, o_tick}, {31'd0, tk});
  endtask

  initial begin
    logic [7:0] e;
    logic [2:0] k3;
    i_rst = 1'b1; i_en = 1'b0; i_mode = 1'b0; i_sel = '0;
    i_last = '0; i_div = '0; i_opt = 1'b0;
    #1;
    chk3("rst_opt0", 8'hFF, 3'd0, 1'b0);
    i_opt = 1'b1;
    #1;
    chk("rst_opt1", {24'd0, o_y}, 32'h00);
    #1 i_rst = 1'b0;

    // Direct decode, active-high then active-low
    i_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      i_sel = 3'(s);
      cyc();
      e = 8'h01 << s;
      chk3("direct_hi", e, 3'(s), 1'b0);
    end
    i_opt = 1'b0;
    for (int s = 0; s < 8; s++) begin
      i_sel = 3'(s);
      cyc();
      e = ~(8'h01 << s);
      chk3("direct_lo", e, 3'(s), 1'b0);
    end

    // Full scan: div=2, last=7, starting from idx 0
    i_opt = 1'b1; i_sel = 3'd0;
    cyc();
    i_mode = 1'b1; i_div = 16'd2; i_last = 3'd7;
    cyc();
    chk3("scan_first", 8'h01, 3'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      k3 = 3'(k - 1);
      e = 8'h01 << k3;
      cyc(); chk3("scan_hold1", e, k3, 1'b0);
      cyc(); chk3("scan_hold2", e, k3, 1'b0);
      k3 = 3'(k % 8);
      e = 8'h01 << k3;
      cyc(); chk3("scan_step", e, k3, 1'b1);
    end

    // Partial scan with div=0: steps every edge through 0..3
    i_last = 3'd3; i_div = 16'd0;
    for (int k = 0; k < 7; k++) begin
      k3 = 3'((k + 1) % 4);
      e = 8'h01 << k3;
      cyc(); chk3("partial", e, k3, 1'b1);
    end
    i_last = 3'd1;
    cyc(); chk3("shrink0", 8'h01, 3'd0, 1'b1);
    cyc(); chk3("shrink1", 8'h02, 3'd1, 1'b1);
    cyc(); chk3("shrink2", 8'h01, 3'd0, 1'b1);

    // Blank at idx 5 and resume
    i_last = 3'd7;
    for (int k = 1; k <= 5; k++) cyc();
    chk3("at5", 8'h20, 3'd5, 1'b1);
    i_div = 16'd2; i_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(); chk3("blank", 8'h00, 3'd5, 1'b0);
    end
    i_en = 1'b1;
    cyc(); chk3("resume", 8'h20, 3'd5, 1'b0);
    cyc(); chk3("resume_h1", 8'h20, 3'd5, 1'b0);
    cyc(); chk3("resume_h2", 8'h20, 3'd5, 1'b0);
    cyc(); chk3("resume_step", 8'h40, 3'd6, 1'b1);

    // Mode switch at idx 2
    i_div = 16'd0;
    cyc(); cyc(); cyc(); cyc();
    chk3("at2", 8'h04, 3'd2, 1'b1);
    i_mode = 1'b0; i_sel = 3'd6;
    cyc(); chk3("to_direct", 8'h40, 3'd6, 1'b0);
    i_mode = 1'b1;
    cyc(); chk3("to_scan", 8'h40, 3'd6, 1'b0);
    cyc(); chk3("to_scan_step", 8'h80, 3'd7, 1'b1);

    // Asynchronous reset mid-scan, then last=0 hold
    i_opt = 1'b0;
    #2 i_rst = 1'b1;
    #1 chk3("async_rst", 8'hFF, 3'd0, 1'b0);
    i_last = 3'd0; i_div = 16'd1; i_opt = 1'b1;
    #1 i_rst = 1'b0;
    cyc(); chk3("rst_resume", 8'h01, 3'd0, 1'b0);
    cyc(); chk3("last0_h", 8'h01, 3'd0, 1'b0);
    cyc(); chk3("last0_t", 8'h01, 3'd0, 1'b1);
    cyc(); chk3("last0_h2", 8'h01, 3'd0, 1'b0);
    cyc(); chk3("last0_t2", 8'h01, 3'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
